// File: rtl/dmem_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_stall_ctrl_pkg
//   Shared definitions for the MEM-stage data-memory sequencer and for the
//   pipeline registers that carry data/addresses around it.
//
//   Contents:
//     XLEN                   - data/address width used by the pipeline
//     DEFAULT_TIMEOUT_CYCLES - default BUSY cycles allowed before an abort
//     state_t                - sequencer state encoding (IDLE/BUSY/DONE)
//     is_mem_access()        - true when the MEM stage wants the data bus
// -----------------------------------------------------------------------------
package dmem_stall_ctrl_pkg;

  localparam int XLEN                   = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A load, a store, or both (both is handled as a store).
  function automatic logic is_mem_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/dmem_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Width-parameterised up-counter that sticks at its all-ones value instead
//   of wrapping. A synchronous clear takes priority over the increment.
//
//   Ports:
//     clk    in  1  clock
//     rst    in  1  asynchronous, active-high reset (count -> 0)
//     clear  in  1  synchronous clear
//     inc    in  1  add one this cycle unless already saturated
//     count  out W  current count, registered
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_stall_ctrl
//   Sequences MEM-stage loads/stores against a variable-latency req/ack data
//   memory. While an access is outstanding the upstream pipeline is frozen and
//   a bubble is pushed into MEM/WB; on the single retire cycle (DONE) the
//   pipeline advances and MEM/WB captures load_data. Bus errors and timeouts
//   are reported as a one-cycle bus_err pulse with the failing address.
//
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     mem_read/mem_write  MEM-stage access request (from EX/MEM)
//     mem_addr/mem_wdata  byte address / store data (from EX/MEM)
//     dmem_req/dmem_we    registered request / write enable to data memory
//     dmem_addr/wdata     address and store data latched at request time
//     dmem_ack/err/rdata  completion, failure and read data from memory
//     stall               freezes PC, IF/ID, ID/EX, EX/MEM (combinational)
//     wb_bubble           zeroes RegWrite/MemToReg into MEM/WB (== stall)
//     load_data           registered read data feeding MEM/WB
//     bus_err             one-cycle pulse when a failed access retires
//     err_addr            address of the most recent failed access
//     stall_count         saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module dmem_stall_ctrl
  import dmem_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TW             = 8,
  parameter int SCW            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic            dmem_err,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            wb_bubble,
  output logic [XLEN-1:0] load_data,
  output logic            bus_err,
  output logic [XLEN-1:0] err_addr,
  output logic [SCW-1:0]  stall_count
);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  logic              req_reg;
  logic              we_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [XLEN-1:0]   load_reg;
  logic              err_pending_reg;
  logic [XLEN-1:0]   err_addr_reg;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic            access;
  logic            in_idle;
  logic            in_busy;
  logic            start;
  logic            tmo_hit;
  logic            fail;
  logic            done_ok;
  logic [TW-1:0]   tmo_count;
  logic [TW-1:0]   tmo_last;

  assign access  = is_mem_access(mem_read, mem_write);
  assign in_idle = (state_reg == ST_IDLE);
  assign in_busy = (state_reg == ST_BUSY);
  assign start   = in_idle & access;

  // The counter holds the number of BUSY cycles already completed, so the
  // current cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1;
  // giving up here means exactly TIMEOUT_CYCLES BUSY cycles are spent.
  assign tmo_last = TW'(TIMEOUT_CYCLES - 1);
  assign tmo_hit  = in_busy & (tmo_count == tmo_last);

  // An error beats a simultaneous ack; an ack in the last allowed cycle beats
  // the timeout.
  assign fail    = in_busy & (dmem_err | (tmo_hit & ~dmem_ack));
  assign done_ok = in_busy & dmem_ack & ~dmem_err;

  // ---------------------------------------------------------------------------
  // Stall (Mealy). Gated by rst so a reset mid-access releases the pipeline in
  // the same cycle even though EX/MEM still presents the request.
  // ---------------------------------------------------------------------------
  assign stall     = ~rst & (start | in_busy);
  assign wb_bubble = stall;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  // Timeout counter: cleared on the IDLE->BUSY transition, counts BUSY cycles.
  sat_counter #(
    .W (TW)
  ) u_tmo_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .inc   (in_busy),
    .count (tmo_count)
  );

  // Total stall cycles since reset; never cleared otherwise.
  sat_counter #(
    .W (SCW)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (stall),
    .count (stall_count)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      req_reg         <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      load_reg        <= '0;
      err_pending_reg <= 1'b0;
      err_addr_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          err_pending_reg <= 1'b0;
          if (access) begin
            // Read+write together is a store.
            req_reg   <= 1'b1;
            we_reg    <= mem_write;
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
            state_reg <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (fail) begin
            err_addr_reg    <= addr_reg;
            err_pending_reg <= 1'b1;
            req_reg         <= 1'b0;
            state_reg       <= ST_DONE;
          end else if (done_ok) begin
            if (!we_reg) begin
              load_reg <= dmem_rdata;
            end
            req_reg   <= 1'b0;
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          // The retiring instruction's request is still on mem_read/mem_write
          // here; it is deliberately ignored so it cannot start a second access.
          err_pending_reg <= 1'b0;
          state_reg       <= ST_IDLE;
        end

        default: begin
          req_reg         <= 1'b0;
          err_pending_reg <= 1'b0;
          state_reg       <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign load_data  = load_reg;
  // The pending flag is only ever set while entering DONE, so it reads as a
  // single-cycle pulse aligned with the retire cycle.
  assign bus_err    = err_pending_reg;
  assign err_addr   = err_addr_reg;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_stall_ctrl
//   Two instances: inst 0 uses the default timeout, inst 1 a timeout of 4.
//   Each transaction is described by its request and the BUSY cycle on which
//   memory answers; the expected per-cycle waveform (stall, req, retire
//   results) is derived from that description, and one compare process checks
//   every output of both instances on every negedge.
// -----------------------------------------------------------------------------
module tb_dmem_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance stimulus
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        dmem_ack  [2];
  logic        dmem_err  [2];
  logic [31:0] dmem_rdata[2];

  // Per-instance observed outputs
  logic        req_o     [2];
  logic        we_o      [2];
  logic [31:0] addr_o    [2];
  logic [31:0] wdata_o   [2];
  logic        stall_o   [2];
  logic        bubble_o  [2];
  logic [31:0] load_o    [2];
  logic        bus_err_o [2];
  logic [31:0] err_addr_o[2];
  logic [31:0] count_o   [2];

  dmem_stall_ctrl dut0 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .dmem_req(req_o[0]), .dmem_we(we_o[0]),
    .dmem_addr(addr_o[0]), .dmem_wdata(wdata_o[0]),
    .dmem_ack(dmem_ack[0]), .dmem_err(dmem_err[0]), .dmem_rdata(dmem_rdata[0]),
    .stall(stall_o[0]), .wb_bubble(bubble_o[0]), .load_data(load_o[0]),
    .bus_err(bus_err_o[0]), .err_addr(err_addr_o[0]), .stall_count(count_o[0])
  );

  dmem_stall_ctrl #(.TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .dmem_req(req_o[1]), .dmem_we(we_o[1]),
    .dmem_addr(addr_o[1]), .dmem_wdata(wdata_o[1]),
    .dmem_ack(dmem_ack[1]), .dmem_err(dmem_err[1]), .dmem_rdata(dmem_rdata[1]),
    .stall(stall_o[1]), .wb_bubble(bubble_o[1]), .load_data(load_o[1]),
    .bus_err(bus_err_o[1]), .err_addr(err_addr_o[1]), .stall_count(count_o[1])
  );

  // Model: visible values and per-cycle expectations
  logic [31:0] m_addr[2], m_wdata[2], m_load[2], m_err_addr[2];
  logic        m_we[2];
  longint      m_count[2];
  logic        e_stall[2], e_req[2], e_bus_err[2];
  logic        chk_en;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stall[%0d]", i),     {63'd0, stall_o[i]},   {63'd0, e_stall[i]});
        chk($sformatf("wb_bubble[%0d]", i), {63'd0, bubble_o[i]},  {63'd0, e_stall[i]});
        chk($sformatf("dmem_req[%0d]", i),  {63'd0, req_o[i]},     {63'd0, e_req[i]});
        if (e_req[i])
          chk($sformatf("dmem_we[%0d]", i), {63'd0, we_o[i]},      {63'd0, m_we[i]});
        chk($sformatf("dmem_addr[%0d]", i), {32'd0, addr_o[i]},    {32'd0, m_addr[i]});
        chk($sformatf("dmem_wdata[%0d]", i),{32'd0, wdata_o[i]},   {32'd0, m_wdata[i]});
        chk($sformatf("load_data[%0d]", i), {32'd0, load_o[i]},    {32'd0, m_load[i]});
        chk($sformatf("bus_err[%0d]", i),   {63'd0, bus_err_o[i]}, {63'd0, e_bus_err[i]});
        chk($sformatf("err_addr[%0d]", i),  {32'd0, err_addr_o[i]},{32'd0, m_err_addr[i]});
        chk($sformatf("stall_count[%0d]", i), {32'd0, count_o[i]}, m_count[i]);
      end
    end
  end

  function automatic int tmo_of(input int u);
    return (u == 0) ? 255 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_load[i] = '0; m_err_addr[i] = '0;
      m_we[i] = 1'b0; m_count[i] = 0;
      e_stall[i] = 1'b0; e_req[i] = 1'b0; e_bus_err[i] = 1'b0;
    end
  endtask

  // Advance one cycle: account last cycle's stall, idle all inputs, default
  // expectations to "nothing happening".
  task automatic new_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (e_stall[i] && m_count[i] != 64'hFFFF_FFFF) m_count[i]++;
      mem_read[i] = 1'b0; mem_write[i] = 1'b0;
      mem_addr[i] = 32'h0; mem_wdata[i] = 32'h0;
      dmem_ack[i] = 1'b0; dmem_err[i] = 1'b0; dmem_rdata[i] = 32'h0;
      e_stall[i] = 1'b0; e_req[i] = 1'b0; e_bus_err[i] = 1'b0;
    end
  endtask

  task automatic drive_req(input int u, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    mem_read[u] = rd; mem_write[u] = wr; mem_addr[u] = addr; mem_wdata[u] = wdata;
  endtask

  // One access. ack_at = BUSY cycle (1-based) on which memory answers, 0 = never.
  task automatic run_txn(input int u, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_at, input bit err);
    int  tmo;
    int  n_busy;
    bit  failed;
    tmo    = tmo_of(u);
    n_busy = (ack_at != 0 && ack_at <= tmo) ? ack_at : tmo;
    failed = err || ack_at == 0 || ack_at > tmo;
    // Request cycle: stalls, nothing latched yet
    new_cycle();
    drive_req(u, rd, wr, addr, wdata);
    e_stall[u] = 1'b1;
    // Waiting for memory
    for (int k = 1; k <= n_busy; k++) begin
      new_cycle();
      drive_req(u, rd, wr, addr, wdata);
      if (k == 1) begin
        m_addr[u] = addr; m_wdata[u] = wdata; m_we[u] = wr;
      end
      e_stall[u] = 1'b1;
      e_req[u]   = 1'b1;
      dmem_rdata[u] = ~rdata;
      if (k == ack_at) begin
        dmem_ack[u]   = 1'b1;
        dmem_err[u]   = err;
        dmem_rdata[u] = rdata;
      end
    end
    // Retire: request still presented by EX/MEM, must not restart
    new_cycle();
    drive_req(u, rd, wr, addr, wdata);
    if (failed) begin
      e_bus_err[u]  = 1'b1;
      m_err_addr[u] = addr;
    end else if (!wr) begin
      m_load[u] = rdata;
    end
    $display("txn inst=%0d %s addr=%08h busy_cycles=%0d stall_cycles=%0d bus_err=%0d",
             u, wr ? "store" : "load", addr, n_busy, n_busy + 1, failed);
  endtask

  // Idle cycles; optionally a stray ack to instance su on idle cycle sk.
  task automatic idle(input int n, input int su, input int sk);
    for (int k = 1; k <= n; k++) begin
      new_cycle();
      if (su >= 0 && k == sk) begin
        dmem_ack[su]   = 1'b1;
        dmem_rdata[su] = 32'hBAD0_BAD0;
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    chk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; mem_addr[i] = '0; mem_wdata[i] = '0;
      dmem_ack[i] = 1'b0; dmem_err[i] = 1'b0; dmem_rdata[i] = '0;
    end
    model_reset();

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_req",   {63'd0, req_o[i]},   64'd0);
      chk("reset_stall", {63'd0, stall_o[i]}, 64'd0);
      chk("reset_load",  {32'd0, load_o[i]},  64'd0);
      chk("reset_count", {32'd0, count_o[i]}, 64'd0);
    end
    new_cycle();
    rst    = 1'b0;
    chk_en = 1'b1;
    idle(1, -1, 0);

    // Load, immediate ack
    run_txn(0, 1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0);
    chk("lit_load1",  {32'd0, load_o[0]},  64'hDEAD_BEEF);
    chk("lit_count1", {32'd0, count_o[0]}, 64'd2);
    idle(2, -1, 0);

    // Store, ack in 5th BUSY cycle
    run_txn(0, 0, 1, 32'h200, 32'h1234_5678, 32'h5555_AAAA, 5, 0);
    chk("lit_count2", {32'd0, count_o[0]}, 64'd8);
    chk("lit_load2",  {32'd0, load_o[0]},  64'hDEAD_BEEF);
    idle(1, -1, 0);

    // Read with err+ack together on BUSY cycle 3
    run_txn(0, 1, 0, 32'h340, 32'h0, 32'hCAFE_F00D, 3, 1);
    chk("lit_err_addr", {32'd0, err_addr_o[0]}, 64'h340);
    chk("lit_bus_err",  {63'd0, bus_err_o[0]},  64'd1);
    idle(1, -1, 0);

    // Back-to-back loads
    run_txn(0, 1, 0, 32'h10, 32'h0, 32'h1111_0010, 1, 0);
    run_txn(0, 1, 0, 32'h14, 32'h0, 32'h2222_0014, 1, 0);
    chk("lit_load_b2b", {32'd0, load_o[0]}, 64'h2222_0014);
    idle(1, -1, 0);

    // Read and write together behaves as a store
    run_txn(0, 1, 1, 32'h600, 32'h0BAD_F00D, 32'h7777_7777, 2, 0);
    chk("lit_rw_we_load", {32'd0, load_o[0]}, 64'h2222_0014);
    idle(1, -1, 0);

    // Timeout on the short-timeout instance, then a stray ack 2 cycles later
    run_txn(1, 1, 0, 32'h400, 32'h0, 32'h0, 0, 0);
    chk("lit_tmo_err_addr", {32'd0, err_addr_o[1]}, 64'h400);
    chk("lit_tmo_count",    {32'd0, count_o[1]},    64'd5);
    idle(4, 1, 2);
    chk("lit_stray_load", {32'd0, load_o[1]}, 64'd0);

    // Reset in the middle of BUSY with the load still requested
    new_cycle();
    drive_req(0, 1, 0, 32'h300, 32'h0);
    e_stall[0] = 1'b1;
    new_cycle();
    drive_req(0, 1, 0, 32'h300, 32'h0);
    m_addr[0] = 32'h300; m_wdata[0] = 32'h0; m_we[0] = 1'b0;
    e_stall[0] = 1'b1; e_req[0] = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_req",   {63'd0, req_o[0]},   64'd0);
    chk("rst_mid_stall", {63'd0, stall_o[0]}, 64'd0);
    chk("rst_mid_addr",  {32'd0, addr_o[0]},  64'd0);
    new_cycle();
    rst = 1'b0;
    idle(1, -1, 0);
    $display("txn inst=0 reset mid-access");

    // Fresh load after reset
    run_txn(0, 1, 0, 32'h500, 32'h0, 32'hA5A5_5A5A, 2, 0);
    chk("lit_post_rst_count", {32'd0, count_o[0]}, 64'd3);
    chk("lit_post_rst_load",  {32'd0, load_o[0]},  64'hA5A5_5A5A);
    idle(2, -1, 0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
